// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel requests, syncs and latency-aligned colour.
// Define VGA_TESTPAT_EN to add pat_sel and the built-in colour-bar pattern.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int RD_LAT   = 1,
    parameter int RGB_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [3*RGB_W-1:0]          data_in,
`ifdef VGA_TESTPAT_EN
    input  logic                        pat_sel,
`endif
    output logic                        req,
    output logic [$clog2(H_ACTIVE)-1:0] req_x,
    output logic [$clog2(V_ACTIVE)-1:0] req_y,
    output logic                        line_start,
    output logic                        frame_start,
    output logic                        hsync,
    output logic                        vsync,
    output logic [RGB_W-1:0]            vga_r,
    output logic [RGB_W-1:0]            vga_g,
    output logic [RGB_W-1:0]            vga_b,
    output logic                        valid
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          pix;
    logic          h_in_sync;
    logic          v_in_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                if (vcnt == V_LAST) begin
                    vcnt <= '0;
                end else begin
                    vcnt <= vcnt + 1'b1;
                end
            end else begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end

    always_comb begin
        pix       = (hcnt < H_ACT) && (vcnt < V_ACT);
        h_in_sync = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
        v_in_sync = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
    end

    // Request stage: one en-cycle behind the counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req         <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            req         <= pix;
            req_x       <= pix ? XW'(hcnt) : '0;
            req_y       <= pix ? YW'(vcnt) : '0;
            line_start  <= pix && (hcnt == '0);
            frame_start <= pix && (hcnt == '0) && (vcnt == '0);
        end
    end

    // Index 0 aligns with req; index RD_LAT aligns with the data_in sample.
    logic [RD_LAT:0] act_pipe;
    logic [RD_LAT:0] hs_pipe;
    logic [RD_LAT:0] vs_pipe;

    always_ff @(posedge clk) begin
        if (!rst) begin
            act_pipe <= '0;
            hs_pipe  <= '0;
            vs_pipe  <= '0;
        end else if (en) begin
            act_pipe <= {act_pipe[RD_LAT-1:0], pix};
            hs_pipe  <= {hs_pipe[RD_LAT-1:0], h_in_sync};
            vs_pipe  <= {vs_pipe[RD_LAT-1:0], v_in_sync};
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [HW-1:0]          bar_q;
    logic [2:0]             bar_c;
    logic [RD_LAT:0][2:0]   bar_pipe;

    always_comb begin
        bar_q = hcnt / HW'(BAR_W);
        bar_c = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bar_pipe <= '0;
        end else if (en) begin
            bar_pipe <= {bar_pipe[RD_LAT-1:0], bar_c};
        end
    end
`endif

    logic [RGB_W-1:0] r_nxt;
    logic [RGB_W-1:0] g_nxt;
    logic [RGB_W-1:0] b_nxt;

    always_comb begin
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        if (act_pipe[RD_LAT]) begin
`ifdef VGA_TESTPAT_EN
            if (pat_sel) begin
                // Bar index bits map to white,yellow,cyan,green,magenta,red,blue,black.
                r_nxt = {RGB_W{~bar_pipe[RD_LAT][1]}};
                g_nxt = {RGB_W{~bar_pipe[RD_LAT][2]}};
                b_nxt = {RGB_W{~bar_pipe[RD_LAT][0]}};
            end else begin
                r_nxt = data_in[3*RGB_W-1:2*RGB_W];
                g_nxt = data_in[2*RGB_W-1:RGB_W];
                b_nxt = data_in[RGB_W-1:0];
            end
`else
            r_nxt = data_in[3*RGB_W-1:2*RGB_W];
            g_nxt = data_in[2*RGB_W-1:RGB_W];
            b_nxt = data_in[RGB_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hsync <= ~HS_ON;
            vsync <= ~VS_ON;
            valid <= 1'b0;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (en) begin
            hsync <= hs_pipe[RD_LAT] ? HS_ON : ~HS_ON;
            vsync <= vs_pipe[RD_LAT] ? VS_ON : ~VS_ON;
            valid <= act_pipe[RD_LAT];
            vga_r <= r_nxt;
            vga_g <= g_nxt;
            vga_b <= b_nxt;
        end
    end

endmodule
